// File: rtl/rst_seq_if.sv
// Reset-sequencer control/status bundle: lock and soft-reset requests in,
// per-channel active-low resets and sequence status out.
interface rst_seq_if #(
    parameter int NUM_CH = 4
);
    logic              pll_locked;
    logic              soft_rst_req;
    logic [NUM_CH-1:0] rst_n_out;
    logic              seq_done;
    logic              lock_lost;

    modport master (
        output pll_locked,
        output soft_rst_req,
        input  rst_n_out,
        input  seq_done,
        input  lock_lost
    );

    modport slave (
        input  pll_locked,
        input  soft_rst_req,
        output rst_n_out,
        output seq_done,
        output lock_lost
    );
endinterface

// File: rtl/rst_seq.sv
// Multi-channel reset sequencer: holds all resets for a minimum time after PLL
// lock, then releases each channel at its own delay; lock loss or soft reset re-runs it.
module rst_seq #(
    parameter int                      NUM_CH         = 4,
    parameter int                      CNT_W          = 28,
    parameter logic [NUM_CH*CNT_W-1:0] CH_DLY         = '0,
    parameter int                      MIN_ASSERT_CYC = 16,
    parameter int                      SYNC_STAGES    = 2
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    rst_seq_if.slave   bus
);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        ASSERT    = 2'd1,
        RELEASE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0]      rst_n_q, rst_n_d;
    logic                   done_q, done_d;
    logic                   lost_q, lost_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic [NUM_CH-1:0]      rel_hit;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // Per-channel release compare against the shared sequence counter.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign rel_hit[k] = (cnt_q >= CH_DLY[k*CNT_W +: CNT_W]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_n_d = rst_n_q;
        done_d  = done_q;
        lost_d  = lost_q;
        if (state_q == WAIT_LOCK) begin
            rst_n_d = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
            if (bus.soft_rst_req) lost_d = 1'b0;
            if (lock_s) state_d = ASSERT;
        end else if (!lock_s) begin
            // Lock loss outranks a coincident soft reset so the sticky flag survives.
            state_d = WAIT_LOCK;
            rst_n_d = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
            if (state_q == DONE) lost_d = 1'b1;
        end else if (bus.soft_rst_req) begin
            state_d = ASSERT;
            cnt_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
            lost_d  = 1'b0;
        end else begin
            case (state_q)
                ASSERT: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RELEASE: begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    rst_n_d = rst_n_q | rel_hit;
                    if (&rst_n_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            rst_n_q <= '0;
            done_q  <= 1'b0;
            lost_q  <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
            lost_q  <= lost_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign bus.rst_n_out = rst_n_q;
    assign bus.seq_done  = done_q;
    assign bus.lock_lost = lost_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: nominal release timing, no-lock, lock loss,
// soft reset, priority and asynchronous reset cases.
module tb_rst_seq;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    rst_seq_if #(.NUM_CH(3)) bus ();

    rst_seq #(
        .NUM_CH        (3),
        .CNT_W         (8),
        .CH_DLY        ({8'd20, 8'd10, 8'd0}),
        .MIN_ASSERT_CYC(4),
        .SYNC_STAGES   (2)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // Count edges after the reference edge until each output rises; pre_or
    // collects every output bit seen at edges before 'quiet'.
    task automatic measure(input int n, input int quiet, output int r0, output int r1,
                           output int r2, output int rd, output logic [3:0] pre_or);
        r0 = -1; r1 = -1; r2 = -1; rd = -1; pre_or = '0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (i < quiet) pre_or |= {bus.seq_done, bus.rst_n_out};
            if (r0 < 0 && bus.rst_n_out[0]) r0 = i;
            if (r1 < 0 && bus.rst_n_out[1]) r1 = i;
            if (r2 < 0 && bus.rst_n_out[2]) r2 = i;
            if (rd < 0 && bus.seq_done)     rd = i;
        end
    endtask

    task automatic check_seq(input string tag, input int base);
        int r0, r1, r2, rd;
        logic [3:0] pre;
        measure(40, base, r0, r1, r2, rd, pre);
        chk({tag, "_ch0"},  r0,  base);
        chk({tag, "_ch1"},  r1,  base + 10);
        chk({tag, "_ch2"},  r2,  base + 20);
        chk({tag, "_done"}, rd,  base + 21);
        chk({tag, "_quiet"}, pre, 0);
    endtask

    initial begin
        logic [3:0] acc;
        bus.pll_locked   = 1'b0;
        bus.soft_rst_req = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_out",  bus.rst_n_out, 3'b000);
        chk("rst_done", bus.seq_done,  1'b0);
        chk("rst_lost", bus.lock_lost, 1'b0);

        // No lock for 200 cycles
        sys_rst_n = 1'b1;
        acc = '0;
        for (int i = 0; i < 200; i++) begin
            tick();
            acc |= {bus.lock_lost, bus.seq_done, bus.rst_n_out};
        end
        chk("nolock_any", acc, 0);

        // Nominal: lock sampled at edge P
        bus.pll_locked = 1'b1;
        tick();
        check_seq("nom", 7);
        chk("nom_lost", bus.lock_lost, 1'b0);

        // Lock loss after DONE, sampled at L
        bus.pll_locked = 1'b0;
        tick();
        tick();
        chk("loss_l1_out", bus.rst_n_out, 3'b111);
        tick();
        chk("loss_out",  bus.rst_n_out, 3'b000);
        chk("loss_done", bus.seq_done,  1'b0);
        chk("loss_lost", bus.lock_lost, 1'b1);

        // Relock re-runs nominal timing; lock_lost stays sticky
        bus.pll_locked = 1'b1;
        tick();
        check_seq("relock", 7);
        chk("relock_lost", bus.lock_lost, 1'b1);

        // Soft reset from DONE at S: ASSERT at S, RELEASE at E=S+4
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        chk("soft_out",  bus.rst_n_out, 3'b000);
        chk("soft_done", bus.seq_done,  1'b0);
        chk("soft_lost", bus.lock_lost, 1'b0);
        repeat (15) tick();
        chk("pre_mid_out", bus.rst_n_out, 3'b011);
        // Soft reset mid-RELEASE at E+12
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        chk("mid_out", bus.rst_n_out, 3'b000);
        check_seq("mid", 5);

        // Priority: soft_rst_req on the edge where lock_s is seen low in DONE
        bus.pll_locked = 1'b0;
        tick();
        tick();
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        chk("prio_out",  bus.rst_n_out, 3'b000);
        chk("prio_done", bus.seq_done,  1'b0);
        chk("prio_lost", bus.lock_lost, 1'b1);
        repeat (10) tick();
        chk("prio_wait_out", {bus.seq_done, bus.rst_n_out}, 4'b0000);
        // soft_rst_req in WAIT_LOCK only clears the sticky flag
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        chk("wait_soft_lost", bus.lock_lost, 1'b0);
        chk("wait_soft_out",  bus.rst_n_out, 3'b000);

        // Reach DONE, then async reset between edges
        bus.pll_locked = 1'b1;
        tick();
        check_seq("pre_async", 7);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async_out",  bus.rst_n_out, 3'b000);
        chk("async_done", bus.seq_done,  1'b0);
        #2 sys_rst_n = 1'b1;
        tick();
        // Mid-ASSERT async reset: P, P+1, A=P+2, P+3
        repeat (3) tick();
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async_asrt_out", {bus.lock_lost, bus.seq_done, bus.rst_n_out}, 5'b00000);
        #2 sys_rst_n = 1'b1;
        tick();
        check_seq("after_async", 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised multi-channel reset sequencer for the DDR/PLL clocking area. It replaces the single fixed-delay DDR reset release with NUM_CH reset outputs, each released at its own programmable delay. Release is gated on a synchronised PLL-lock input, and loss of lock or a soft-reset request re-runs the sequence. It sits between the board reset/PLL and the DDR controller, PHY and user-logic reset domains.

## Interface
- NUM_CH, 4: number of reset outputs, 1..16.
- CNT_W, 28: sequence counter width.
- CH_DLY, {NUM_CH{CNT_W'd0}}: packed delays; channel k uses bits [k*CNT_W +: CNT_W], measured in cycles from RELEASE entry.
- MIN_ASSERT_CYC, 16: minimum cycles all resets are held asserted after lock, ≥1, < 2^CNT_W.
- SYNC_STAGES, 2: flip-flop stages on pll_locked, ≥2.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset; one clock (sys_clk).
- pll_locked  in  1  PLL lock, asynchronous to sys_clk; passes through a SYNC_STAGES synchroniser to give lock_s.
- soft_rst_req  in  1  synchronous one-cycle pulse that restarts the sequence.
- rst_n_out  out  NUM_CH  active-low reset per channel, registered.
- seq_done  out  1  high when all channels are released, registered.
- lock_lost  out  1  sticky flag: lock dropped after seq_done; cleared by soft_rst_req or sys_rst_n.

## Operation
- States: WAIT_LOCK, ASSERT, RELEASE, DONE. Reset state is WAIT_LOCK.
- Reset values: rst_n_out=0, seq_done=0, lock_lost=0, cnt=0, synchroniser=0.
- WAIT_LOCK: all rst_n_out=0 and cnt=0. Goes to ASSERT when lock_s=1.
- ASSERT:
  - All rst_n_out stay 0; cnt increments.
  - When cnt==MIN_ASSERT_CYC-1, goes to RELEASE with cnt<=0.
- RELEASE:
  - cnt increments and saturates at 2^CNT_W-1.
  - Each cycle, rst_n_out[k]<=1 if cnt>=CH_DLY[k]. A released channel stays released.
  - When all rst_n_out are already 1, goes to DONE with seq_done<=1.
- DONE: holds all outputs; cnt frozen.
- Lock loss (lock_s=0) in ASSERT, RELEASE or DONE:
  - Goes to WAIT_LOCK; rst_n_out<=0, seq_done<=0, all in the same edge.
  - lock_lost<=1 if the state was DONE.
- soft_rst_req=1 in ASSERT, RELEASE or DONE (with lock_s=1):
  - Goes to ASSERT with cnt<=0; rst_n_out<=0, seq_done<=0, lock_lost<=0.
  - In ASSERT, this restarts the minimum-hold count.
- soft_rst_req in WAIT_LOCK: only clears lock_lost.
- Priority: sys_rst_n > lock loss > soft_rst_req > normal progression.
- CH_DLY need not be monotonic; channels release independently.
- seq_done still waits for the largest delay.
- Equal delays release in the same cycle.
- CH_DLY[k]=0 releases on the first RELEASE cycle.

## Timing
- pll_locked sampled at edge P → lock_s=1 at P+SYNC_STAGES-1 → ASSERT entered at edge A=P+SYNC_STAGES.
- RELEASE entered at edge E=A+MIN_ASSERT_CYC.
- rst_n_out[k] rises at edge E+CH_DLY[k]+1.
- seq_done rises at edge E+max(CH_DLY)+2.
- Lock drop sampled at edge L → all rst_n_out low and seq_done low at edge L+SYNC_STAGES.
- soft_rst_req high at edge S → rst_n_out low at S, ASSERT entered at S, RELEASE at S+MIN_ASSERT_CYC.
- sys_rst_n low: all outputs 0 immediately (asynchronous). Release of sys_rst_n restarts from WAIT_LOCK.
- The pll_locked synchroniser is also reset by sys_rst_n.

## Test plan
Bench parameters: NUM_CH=3, CNT_W=8, CH_DLY={8'd20,8'd10,8'd0} (ch2..ch0), MIN_ASSERT_CYC=4, SYNC_STAGES=2.
- Nominal sequence. Stimulus: release sys_rst_n, pll_locked=1 sampled at edge P. Required:
  - rst_n_out[0] rises at P+7, [1] at P+17, [2] at P+27.
  - seq_done rises at P+28.
  - All outputs are 0 before P+7.
- No lock. Stimulus: pll_locked held 0 for 200 cycles. Required: rst_n_out=3'b000, seq_done=0 throughout, state stays WAIT_LOCK.
- Lock loss after DONE. Stimulus: pll_locked drops, sampled at L. Required:
  - rst_n_out=000, seq_done=0, lock_lost=1 at L+2.
  - Relock re-runs the full nominal timing.
  - lock_lost stays 1 until a soft_rst_req.
- Soft reset mid-RELEASE. Stimulus: soft_rst_req pulse at E+12 (ch0 and ch1 already released). Required:
  - rst_n_out=000 at E+12.
  - Release restarts: ch0 at E+17, ch1 at E+27, ch2 at E+37.
- Priority. Stimulus: soft_rst_req coincides with lock_s falling while in DONE. Required: WAIT_LOCK entered, lock_lost=1.
- Asynchronous reset mid-ASSERT. Stimulus: sys_rst_n pulsed low between edges. Required:
  - Outputs 0 without a clock edge.
  - After release, the sequence restarts with latency identical to the nominal case.
